// File: rtl/issue_port_arbiter_pkg.sv
// ============================================================================
// Module      : issue_port_arbiter_pkg
// Description : Shared types for the issue-port arbiter: the issue payload,
//               the default option-code payload and the source-index type.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package issue_port_arbiter_pkg;

  // Default number of reservation stations sharing one issue port.
  localparam int ISSUE_PORT_REQ_NUM = 4;

  // Index of the reservation station that won the port.
  typedef logic [$clog2(ISSUE_PORT_REQ_NUM)-1:0] IssuePortSrcT;

  // Generic issue payload carried from a reservation-station head to the FU.
  typedef struct packed {
    logic [5:0] rob_idx;
    logic [6:0] dst_preg;
    logic [6:0] src1_preg;
    logic [6:0] src2_preg;
    logic [4:0] flags;
  } IssueBaseSt;

  // Default FU-specific option code.
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] size;
    logic       is_signed;
  } OptionCodeSt;

endpackage

`default_nettype wire

// File: rtl/issue_port_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Scans the request vector
//               starting at start_i and wrapping, returns a one-hot grant,
//               the winner index and an any-request flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker
  import issue_port_arbiter_pkg::*;
#(
  parameter  int REQ_NUM = 4,
  localparam int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [REQ_NUM-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // First set request at or after start_i, with wrap-around.
  always_comb begin
    int pos;
    pos     = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      pos = int'(start_i) + k;
      if (pos >= REQ_NUM) pos = pos - REQ_NUM;
      if (!any_o && req_i[IDX_W'(pos)]) begin
        any_o                 = 1'b1;
        idx_o                 = IDX_W'(pos);
        grant_o[IDX_W'(pos)]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_port_arbiter.sv
// ============================================================================
// Module      : issue_port_arbiter
// Description : Shares one FU issue port between REQ_NUM in-order reservation
//               stations. Round-robin pick, one-deep registered output stage,
//               grant blocking while a non-pipelined op occupies the FU.
//               Optional per-requester stall counters are compiled in with
//               the macro ISSUE_ARB_PERF_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_port_arbiter
  import issue_port_arbiter_pkg::*;
#(
  parameter  int  REQ_NUM     = 4,
  parameter  type OPTION_CODE = OptionCodeSt,
  parameter  int  MAX_OCCUPY  = 8,
  localparam int  OCC_W       = $clog2(MAX_OCCUPY + 1),
  localparam int  SRC_W       = $clog2(REQ_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic       [REQ_NUM-1:0]        req_valid_i,
  output logic       [REQ_NUM-1:0]        req_ready_o,
  input  IssueBaseSt [REQ_NUM-1:0]        req_base_i,
  input  OPTION_CODE [REQ_NUM-1:0]        req_oc_i,
  input  logic       [REQ_NUM-1:0][OCC_W-1:0] req_occupy_i,
  output logic                            fu_valid_o,
  input  logic                            fu_ready_i,
  output IssueBaseSt                      fu_base_o,
  output OPTION_CODE                      fu_oc_o,
  output logic       [SRC_W-1:0]          fu_src_o
`ifdef ISSUE_ARB_PERF_CNT_EN
  ,
  output logic       [REQ_NUM-1:0][31:0]  stall_cnt_o
`endif
);

  logic                 out_valid_q, out_valid_d;
  IssueBaseSt           base_q, base_d;
  OPTION_CODE           oc_q, oc_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [SRC_W-1:0]     rr_q, rr_d;
  logic [OCC_W-1:0]     busy_q, busy_d;

  logic                 w_can_load;
  logic [REQ_NUM-1:0]   w_pick_onehot;
  logic [SRC_W-1:0]     w_win_idx;
  logic                 w_pick_any;
  logic                 w_grant;
  logic [OCC_W-1:0]     w_occ_sel;
  logic [OCC_W-1:0]     w_busy_load;
  logic [SRC_W-1:0]     w_rr_next;

  rr_picker #(
    .REQ_NUM (REQ_NUM)
  ) u_picker (
    .req_i   (req_valid_i),
    .start_i (rr_q),
    .grant_o (w_pick_onehot),
    .idx_o   (w_win_idx),
    .any_o   (w_pick_any)
  );

  // The stage can accept when it is empty or draining, the FU is free and no
  // flush/reset is in progress; req_valid_i never depends on req_ready_o.
  assign w_can_load  = (~out_valid_q | fu_ready_i) & (busy_q == '0) & ~flush_i & ~rst;
  assign w_grant     = w_can_load & w_pick_any;
  assign req_ready_o = w_pick_onehot & {REQ_NUM{w_can_load}};

  // Occupancy 0 behaves as 1; the counter holds the extra cycles beyond the first.
  assign w_occ_sel   = req_occupy_i[w_win_idx];
  assign w_busy_load = (w_occ_sel == '0) ? '0 : w_occ_sel - OCC_W'(1);
  assign w_rr_next   = (w_win_idx == SRC_W'(REQ_NUM - 1)) ? '0 : w_win_idx + SRC_W'(1);

  // Next-state for output stage, round-robin pointer and busy counter.
  always_comb begin
    out_valid_d = out_valid_q;
    base_d      = base_q;
    oc_d        = oc_q;
    src_d       = src_q;
    rr_d        = rr_q;
    busy_d      = busy_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      busy_d      = '0;
      rr_d        = '0;
    end else if (w_grant) begin
      out_valid_d = 1'b1;
      base_d      = req_base_i[w_win_idx];
      oc_d        = req_oc_i[w_win_idx];
      src_d       = w_win_idx;
      rr_d        = w_rr_next;
      busy_d      = w_busy_load;
    end else begin
      if (fu_ready_i) out_valid_d = 1'b0;
      if (busy_q != '0) busy_d = busy_q - OCC_W'(1);
    end
  end

  // State registers; reset also clears the held payload and source index.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      base_q      <= '0;
      oc_q        <= '0;
      src_q       <= '0;
      rr_q        <= '0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      base_q      <= base_d;
      oc_q        <= oc_d;
      src_q       <= src_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
    end
  end

  assign fu_valid_o = out_valid_q;
  assign fu_base_o  = base_q;
  assign fu_oc_o    = oc_q;
  assign fu_src_o   = src_q;

`ifdef ISSUE_ARB_PERF_CNT_EN
  for (genvar i = 0; i < REQ_NUM; i++) begin : g_perf_cnt
    logic [31:0] cnt_q;
    // Saturating count of cycles requester i was valid but not granted.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (req_valid_i[i] && !req_ready_o[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign stall_cnt_o[i] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_port_arbiter.sv
// ============================================================================
// Module      : tb_issue_port_arbiter
// Description : Self-checking bench for issue_port_arbiter: directed scenario
//               tasks plus randomized traffic against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_issue_port_arbiter;
  import issue_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int OW = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  IssueBaseSt [N-1:0]      req_base;
  OptionCodeSt [N-1:0]     req_oc;
  logic [N-1:0][OW-1:0]    req_occ;
  logic                    fu_valid;
  logic                    fu_ready;
  IssueBaseSt              fu_base;
  OptionCodeSt             fu_oc;
  logic [1:0]              fu_src;
`ifdef ISSUE_ARB_PERF_CNT_EN
  logic [N-1:0][31:0]      stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_port_arbiter #(
    .REQ_NUM     (N),
    .OPTION_CODE (OptionCodeSt),
    .MAX_OCCUPY  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_base_i   (req_base),
    .req_oc_i     (req_oc),
    .req_occupy_i (req_occ),
    .fu_valid_o   (fu_valid),
    .fu_ready_i   (fu_ready),
    .fu_base_o    (fu_base),
    .fu_oc_o      (fu_oc),
    .fu_src_o     (fu_src)
`ifdef ISSUE_ARB_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    flush     = 1'b0;
    fu_ready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_base[i] = $urandom;
      req_oc[i]   = 7'($urandom);
      req_occ[i]  = 4'd1;
    end
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 4'b0010;
    fu_ready  = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tick();
    total++; if (fu_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fu_valid); end
    total++; if (fu_base !== IssueBaseSt'(0)) begin bad++; $display("FAIL reset_base got=%h exp=0", fu_base); end
    total++; if (fu_oc !== OptionCodeSt'(0)) begin bad++; $display("FAIL reset_oc got=%h exp=0", fu_oc); end
    total++; if (fu_src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", fu_src); end
    rst = 1'b0;
    fu_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_rr got=%b exp=0001", req_ready); end
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (req_ready !== 4'(1 << (c % N))) begin bad++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % N))); end
      tick();
      total++; if (fu_valid !== 1'b1 || fu_src !== 2'(c % N) || fu_base !== req_base[2'(c % N)]) begin
        bad++; $display("FAIL fair_out c=%0d got v=%b src=%0d base=%h exp v=1 src=%0d base=%h", c, fu_valid, fu_src, fu_base, c % N, req_base[2'(c % N)]);
      end
    end
  endtask

  task automatic test_stall();
    IssueBaseSt held;
    do_reset();
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_first got=%b exp=0010", req_ready); end
    held = req_base[1];
    tick();
    fu_ready  = 1'b0;
    req_valid = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=0000", c, req_ready); end
      total++; if (fu_valid !== 1'b1 || fu_src !== 2'd1 || fu_base !== held) begin
        bad++; $display("FAIL stall_hold c=%0d got v=%b src=%0d base=%h exp v=1 src=1 base=%h", c, fu_valid, fu_src, fu_base, held);
      end
      tick();
    end
    fu_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL stall_release got=%b exp=0100", req_ready); end
    tick();
    total++; if (fu_src !== 2'd2) begin bad++; $display("FAIL stall_next_src got=%0d exp=2", fu_src); end
  endtask

  task automatic test_multicycle();
    do_reset();
    req_valid  = 4'b0011;
    req_occ[0] = 4'd4;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL multi_grant0 got=%b exp=0001", req_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL multi_busy c=%0d got=%b exp=0000", c, req_ready); end
      tick();
    end
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL multi_grant1 got=%b exp=0010", req_ready); end
    tick();
  endtask

  task automatic test_occ_zero();
    do_reset();
    req_valid  = 4'b0100;
    req_occ[2] = 4'd0;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL occ0_first got=%b exp=0100", req_ready); end
    tick();
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL occ0_next got=%b exp=0100", req_ready); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    req_valid  = 4'b0001;
    req_occ[0] = 4'd4;
    fu_ready   = 1'b0;
    tick();
    req_valid = 4'b1111;
    flush     = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
    tick();
    flush    = 1'b0;
    fu_ready = 1'b1;
    #1;
    total++; if (fu_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", fu_valid); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL flush_rr got=%b exp=0001", req_ready); end
    tick();
  endtask

  task automatic test_random();
    int m_valid, m_rr, m_busy, m_src, w, occ;
    bit can;
    logic [N-1:0] exp_ready, shifted;
    IssueBaseSt  m_base;
    OptionCodeSt m_oc;
    do_reset();
    m_valid = 0; m_rr = 0; m_busy = 0; m_src = 0; m_base = '0; m_oc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      fu_ready  = ($urandom_range(0, 9) < 7);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_base[i] = $urandom;
        req_oc[i]   = 7'($urandom);
        req_occ[i]  = 4'($urandom_range(0, 4));
      end
      #1;
      can = (m_valid == 0 || fu_ready) && m_busy == 0 && !flush && !rst;
      w = -1;
      for (int k = 0; k < N; k++) begin
        shifted = req_valid >> ((m_rr + k) % N);
        if (w < 0 && shifted[0]) w = (m_rr + k) % N;
      end
      exp_ready = (can && w >= 0) ? 4'(1 << w) : 4'b0000;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      total++; if (fu_valid !== (m_valid != 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%0d", cyc, fu_valid, m_valid); end
      if (m_valid != 0) begin
        total++; if (fu_src !== 2'(m_src) || fu_base !== m_base || fu_oc !== m_oc) begin
          bad++; $display("FAIL rand_payload cyc=%0d got src=%0d base=%h oc=%h exp src=%0d base=%h oc=%h", cyc, fu_src, fu_base, fu_oc, m_src, m_base, m_oc);
        end
      end
      if (rst || flush) begin
        m_valid = 0; m_busy = 0; m_rr = 0;
        if (rst) begin m_base = '0; m_oc = '0; m_src = 0; end
      end else if (can && w >= 0) begin
        occ     = int'(req_occ[2'(w)]);
        m_valid = 1;
        m_base  = req_base[2'(w)];
        m_oc    = req_oc[2'(w)];
        m_src   = w;
        m_rr    = (w + 1) % N;
        m_busy  = (occ == 0) ? 0 : occ - 1;
      end else begin
        if (fu_ready) m_valid = 0;
        if (m_busy > 0) m_busy = m_busy - 1;
      end
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;
  endtask

`ifdef ISSUE_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    req_valid  = 4'b0001;
    req_occ[0] = 4'd6;
    tick();
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) tick();
    req_valid = 4'b0000;
    #1;
    total++; if (stall_cnt[3] !== 32'd5) begin bad++; $display("FAIL perf_cnt3 got=%0d exp=5", stall_cnt[3]); end
    total++; if (stall_cnt[0] !== 32'd0) begin bad++; $display("FAIL perf_cnt0 got=%0d exp=0", stall_cnt[0]); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (stall_cnt[3] !== 32'd5) begin bad++; $display("FAIL perf_flush got=%0d exp=5", stall_cnt[3]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL perf_rst got=%h exp=0", stall_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_fairness();
    test_stall();
    test_multicycle();
    test_occ_zero();
    test_flush();
    test_random();
`ifdef ISSUE_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_port_arbiter.md
# issue_port_arbiter

Shares one execution-unit issue port between `REQ_NUM` in-order reservation stations. Each cycle it picks one ready head entry by round-robin and registers it into a one-deep output stage toward the FU. It blocks further grants while a multi-cycle (non-pipelined) operation occupies the unit. It sits between the reservation-station issue outputs and the FU's register-read stage.

## Interface
Parameters:
- `REQ_NUM`, 4: number of requesting reservation stations (≥2).
- `OPTION_CODE`, `OptionCodeSt`: option-code payload type.
- `MAX_OCCUPY`, 8: maximum FU occupancy in cycles; counter width is `$clog2(MAX_OCCUPY+1)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  pipeline flush.
- `req_valid_i`  in  `REQ_NUM`  head entry of RS i is issuable.
- `req_ready_o`  out  `REQ_NUM`  grant/accept to RS i; at most one bit high.
- `req_base_i`  in  `REQ_NUM` × `IssueBaseSt`  issue payloads.
- `req_oc_i`  in  `REQ_NUM` × `OPTION_CODE`  option codes.
- `req_occupy_i`  in  `REQ_NUM` × `$clog2(MAX_OCCUPY+1)`  FU cycles consumed by the op; 0 is treated as 1.
- `fu_valid_o`  out  1  output stage holds an op.
- `fu_ready_i`  in  1  FU accepts the op.
- `fu_base_o`  out  `IssueBaseSt`  registered payload.
- `fu_oc_o`  out  `OPTION_CODE`  registered option code.
- `fu_src_o`  out  `$clog2(REQ_NUM)`  index of the granting RS.

## Operation
- State:
  - Output register (`out_valid`, payload, src).
  - Round-robin pointer `rr_q`.
  - Busy counter `busy_q`.
- `can_load = (~out_valid | fu_ready_i) & (busy_q == 0) & ~flush_i & ~rst`.
- Winner: the first valid requester scanning `rr_q, rr_q+1, …` mod `REQ_NUM`.
- `req_ready_o[w] = can_load & req_valid_i[w]`. All other bits are 0.
- `req_valid_i` must not depend on `req_ready_o`, so no combinational loop forms.
- On grant:
  - Load the output register from requester w.
  - `rr_q <= (w == REQ_NUM-1) ? 0 : w+1`, with explicit wrap.
  - `busy_q <= max(req_occupy_i[w],1) - 1`.
- With no grant, `rr_q` holds.
- FU handshake: `fu_valid_o & fu_ready_i` consumes the op. If nothing is loaded in the same cycle, `out_valid <= 0`.
- Same-cycle consume and load: the new op replaces the old one, giving back-to-back throughput of 1/cycle for occupancy-1 ops.
- Busy counter:
  - Decrements by 1 each cycle while nonzero, independent of `fu_ready_i`.
  - A grant can only occur when `busy_q == 0`, so load and decrement never coincide.
- Stall: `fu_valid_o & ~fu_ready_i` holds payload and src stable and forces `req_ready_o = 0`.
- Flush (`flush_i=1`), effective the next cycle:
  - `out_valid`, `busy_q`, and `rr_q` clear to 0.
  - `req_ready_o` is 0 during the flush cycle.
  - Any op presented that cycle is dropped.
- Reset has the same effect as flush. It also clears the payload, `fu_src_o`, and (when compiled in) the perf counters to 0.

## Timing
- Reset values:
  - `fu_valid_o=0`, `fu_base_o='0`, `fu_oc_o='0`, `fu_src_o=0`.
  - `req_ready_o=0` during reset.
  - Internally `rr_q=0`, `busy_q=0`.
- Latency: grant in cycle N gives `fu_valid_o=1` in cycle N+1.
- An op with occupancy k granted in cycle N: the next grant is possible no earlier than cycle N+k, assuming no FU stall.
- Reset or flush asserted mid-stall or mid-busy: the pending op is lost. The first grant can happen in the cycle after deassertion.

## Configuration
- `ISSUE_ARB_PERF_CNT_EN`:
  - Defined: adds output `stall_cnt_o`, `REQ_NUM` × 32 bits. Counter i increments (saturating at all-ones) every cycle with `req_valid_i[i] & ~req_ready_o[i]`. Counters clear on `rst` only; `flush_i` does not clear them.
  - Undefined: the port and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package (`Scheduler.svh`): reuse `IssueBaseSt`. Add `typedef logic [$clog2(REQ_NUM)-1:0] IssuePortSrcT`.
- Sub-module `rr_picker`: purely combinational. Inputs are the request vector and the start pointer. Outputs are a one-hot grant, the winner index, and an any-valid flag.
- Everything else (output stage, counters) lives in `issue_port_arbiter`.

## Test plan
- Fairness: `REQ_NUM=4`, all `req_valid_i=4'b1111`, occupancy 1, `fu_ready_i=1` → grants 0,1,2,3,0 on consecutive cycles; `fu_valid_o` is continuously 1 from the cycle after the first grant.
- FU stall: RS1 granted, then `fu_ready_i=0` for 3 cycles → `fu_base_o` and `fu_src_o=1` are stable; `req_ready_o=0` for all 3 cycles; when `fu_ready_i=1`, the next grant goes to RS2 in that same cycle.
- Multi-cycle op: RS0 with occupy=4 granted in cycle 10, RS1 valid throughout → no grant in cycles 11–13; RS1 is granted in cycle 14.
- Occupancy 0: RS2 with occupy=0 → treated as 1; the next grant is in the following cycle.
- Flush: `flush_i` pulsed while `fu_valid_o=1` and `busy_q=3` → next cycle `fu_valid_o=0`, and the first grant goes to RS0 (`rr_q=0`) in the cycle after the flush.
- Perf counters (`ISSUE_ARB_PERF_CNT_EN`): RS3 valid for 5 cycles while RS0 holds the port → `stall_cnt_o[3]=5`; after `rst`, all counters read 0.
